// File: rtl/led_blink_queue_pkg.sv
// Shared types and helpers for the LED blink queue.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package led_blink_queue_pkg;

    // FSM state encodings; 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Timer width wide enough for the longer of the two phases (minus one).
    // Clamped to 1 bit so single-cycle phases still get a real register.
    function automatic int timer_width(input int on_cycles, input int off_cycles);
        int longest;
        longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Reloadable down-counter that holds at zero; done_o flags the zero count.
// Latency: a load takes effect on the next clock; done_o is decoded from the register.
// Backpressure: none, load_i always wins over counting.
//
// Ports:
//   clk_i        clock
//   resetn_btn_i asynchronous active-low reset (count cleared to 0)
//   load_i       load load_val_i on this clock edge
//   load_val_i   value to load
//   done_o       count is zero
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             resetn_btn_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge resetn_btn_i) begin
        if (!resetn_btn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/led_blink_queue.sv
// Turns event pulses into fixed-length LED blinks separated by fixed dark gaps, queueing extras.
// Latency: led_o rises the cycle after a pulse seen in IDLE; queued events replay after each gap.
// Backpressure: none; events beyond MAX_PENDING are dropped and flagged on overflow_o.
//
// Ports:
//   clk_i        clock, rising edge
//   resetn_btn_i asynchronous active-low reset; release is expected synchronous to clk_i
//   pulse_i      event strobe, each high cycle is one event
//   led_o        blink output (registered)
//   busy_o       high whenever not IDLE (registered)
//   pending_o    queued-event count (registered)
//   overflow_o   one-cycle pulse per dropped event (registered)
module led_blink_queue
    import led_blink_queue_pkg::*;
#(
    parameter  int ON_CYCLES   = 100,
    parameter  int OFF_CYCLES  = 50,
    parameter  int MAX_PENDING = 7,
    localparam int PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk_i,
    input  logic              resetn_btn_i,
    input  logic              pulse_i,
    output logic              led_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pending_o,
    output logic              overflow_o
);

    localparam int                TMR_W    = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0]  OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    state_e            state_q;
    logic              led_q;
    logic              busy_q;
    logic [PEND_W-1:0] pending_q;
    logic [PEND_W-1:0] pending_d;
    logic              overflow_q;
    logic              overflow_d;

    logic              done;
    logic              idle_start;
    logic              on_end;
    logic              gap_end;
    logic              gap_restart;
    logic              timer_load;
    logic [TMR_W-1:0]  timer_load_val;

    // Phase boundaries. The timer is reloaded on the same edge the FSM
    // changes phase, so the new phase sees its full count from its first cycle.
    assign idle_start     = (state_q == ST_IDLE) && pulse_i;
    assign on_end         = (state_q == ST_ON) && done;
    assign gap_end        = (state_q == ST_GAP) && done;
    assign gap_restart    = gap_end && ((pending_q != '0) || pulse_i);
    assign timer_load     = idle_start || on_end || gap_restart;
    assign timer_load_val = on_end ? OFF_LOAD : ON_LOAD;

    cycle_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk_i        (clk_i),
        .resetn_btn_i (resetn_btn_i),
        .load_i       (timer_load),
        .load_val_i   (timer_load_val),
        .done_o       (done)
    );

    // Pending counter. On the last gap cycle a queued event is dequeued and a
    // simultaneous pulse takes its slot, so that path can never overflow. With
    // an empty queue a last-gap pulse starts the next blink directly instead.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = 1'b0;
        if (gap_end) begin
            if (pending_q != '0) begin
                pending_d = pending_q - PEND_W'(1) + PEND_W'(pulse_i);
            end
        end else if ((state_q == ST_ON) || (state_q == ST_GAP)) begin
            if (pulse_i) begin
                if (pending_q < PEND_MAX) begin
                    pending_d = pending_q + PEND_W'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end else if (state_q != ST_IDLE) begin
            // Illegal encoding: drop the queue so IDLE stays empty.
            pending_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_btn_i) begin
        if (!resetn_btn_i) begin
            state_q    <= ST_IDLE;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            case (state_q)
                ST_IDLE: begin
                    if (pulse_i) begin
                        state_q <= ST_ON;
                        led_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (done) begin
                        state_q <= ST_GAP;
                        led_q   <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (done) begin
                        if (gap_restart) begin
                            state_q <= ST_ON;
                            led_q   <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    led_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led_o      = led_q;
    assign busy_o     = busy_q;
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule
